// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix definitions: transfer, response and burst encodings
// plus the round-robin search used by the output-stage arbiter.
package ahb_matrix_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  localparam int unsigned MAX_IN = 8;

  // First requester after 'last' in circular order; returns n when none request.
  function automatic int unsigned rr_next(input logic [MAX_IN-1:0] req,
                                          input int unsigned n,
                                          input int unsigned last);
    int unsigned found;
    int unsigned idx;
    found = n;
    for (int unsigned k = 1; k <= MAX_IN; k++) begin
      idx = (last + k) % n;
      if (k <= n && found == n && req[idx[2:0]])
        found = idx;
    end
    return found;
  endfunction

endpackage

// File: rtl/ahb_matrix_rr_arb.sv
// Round-robin arbiter for one matrix output port: picks the next requester
// after last_port when enabled.
module ahb_matrix_rr_arb
  import ahb_matrix_pkg::*;
#(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned PW     = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PW-1:0]     last_port,
  input  logic              en,
  output logic [PW-1:0]     winner,
  output logic              valid
);

  logic [MAX_IN-1:0] req_ext;
  int unsigned       pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_IN-1:0] = req;
    pick                = rr_next(req_ext, NUM_IN, 32'(last_port));
    winner              = PW'(pick);
    valid               = en && (pick < NUM_IN);
  end

endmodule

// File: rtl/ahb_matrix_output_stage.sv
// AHB matrix output stage: arbitrates NUM_IN decoders onto one AHB-Lite master.
// Define AHB_OUTSTAGE_LOCK_EN to hold the grant for locked sequences and drive HMASTLOCKM.
module ahb_matrix_output_stage
  import ahb_matrix_pkg::*;
#(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned PW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_IN-1:0]    sel_op,
  input  logic [NUM_IN*AW-1:0] addr_op,
  input  logic [NUM_IN*2-1:0]  trans_op,
  input  logic [NUM_IN-1:0]    write_op,
  input  logic [NUM_IN*3-1:0]  size_op,
  input  logic [NUM_IN*3-1:0]  burst_op,
  input  logic [NUM_IN*4-1:0]  prot_op,
  input  logic [NUM_IN-1:0]    mastlock_op,
  input  logic [NUM_IN*DW-1:0] wdata_op,
  input  logic                 HREADYM,
  output logic [NUM_IN-1:0]    active_op,
  output logic                 readyout_op,
  output logic [1:0]           resp_op,
  output logic                 HSELM,
  output logic [AW-1:0]        HADDRM,
  output logic [1:0]           HTRANSM,
  output logic                 HWRITEM,
  output logic [2:0]           HSIZEM,
  output logic [2:0]           HBURSTM,
  output logic [3:0]           HPROTM,
  output logic                 HMASTLOCKM,
  output logic [DW-1:0]        HWDATAM,
  input  logic                 HREADYOUTM,
  input  logic [1:0]           HRESPM
);

  logic [PW-1:0]     addr_port, last_port, data_port;
  logic              data_valid;
  logic [NUM_IN-1:0] sel_eff, req;
  logic [1:0]        cur_trans;
  logic              cur_sel, burst_hold, lock_hold, arb_en;
  logic [PW-1:0]     arb_winner, g;
  logic              arb_valid;

  // Selects are masked while reset is asserted so nothing reaches the slave.
  always_comb begin
    sel_eff = HRESET ? '0 : sel_op;
    for (int unsigned i = 0; i < NUM_IN; i++)
      req[i] = sel_eff[i] & trans_op[2*i+1];
  end

  assign cur_sel    = sel_eff[addr_port];
  assign cur_trans  = trans_op[addr_port*2 +: 2];
  assign burst_hold = cur_sel && (cur_trans == TRANS_SEQ || cur_trans == TRANS_BUSY);

`ifdef AHB_OUTSTAGE_LOCK_EN
  assign lock_hold  = cur_sel & mastlock_op[addr_port];
`else
  logic unused_mastlock;
  assign lock_hold       = 1'b0;
  assign unused_mastlock = ^mastlock_op;
`endif

  assign arb_en = HREADYM & ~(burst_hold | lock_hold);

  ahb_matrix_rr_arb #(
    .NUM_IN (NUM_IN),
    .PW     (PW)
  ) u_arb (
    .req       (req),
    .last_port (last_port),
    .en        (arb_en),
    .winner    (arb_winner),
    .valid     (arb_valid)
  );

  assign g = arb_valid ? arb_winner : addr_port;

  always_comb begin
    HSELM   = sel_eff[g];
    HTRANSM = HSELM ? trans_op[g*2 +: 2] : TRANS_IDLE;
    HADDRM  = addr_op[g*AW +: AW];
    HWRITEM = write_op[g];
    HSIZEM  = size_op[g*3 +: 3];
    HBURSTM = burst_op[g*3 +: 3];
    HPROTM  = prot_op[g*4 +: 4];
`ifdef AHB_OUTSTAGE_LOCK_EN
    HMASTLOCKM = HSELM & mastlock_op[g];
`else
    HMASTLOCKM = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_IN; i++)
      active_op[i] = (g == PW'(i)) && sel_eff[i];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_port  <= '0;
      last_port  <= PW'(NUM_IN - 1);
      data_port  <= '0;
      data_valid <= 1'b0;
    end else begin
      addr_port <= g;
      if (arb_valid)
        last_port <= arb_winner;
      if (HREADYM) begin
        data_port  <= g;
        data_valid <= HSELM & HTRANSM[1];
      end
    end
  end

  assign HWDATAM     = wdata_op[data_port*DW +: DW];
  assign readyout_op = data_valid ? HREADYOUTM : 1'b1;
  assign resp_op     = data_valid ? HRESPM : RESP_OKAY;

endmodule

// File: doc/ahb_matrix_output_stage.md
Name: ahb_matrix_output_stage

Overview:
- Master-side end of the AHB bus matrix: one instance per matrix output port.
- Arbitrates among NUM_IN input-stage decoders, each of which raises a select toward this port. Drives a single AHB-Lite master interface to the downstream slave.
- Returns per-input active, ready and response signals to the decoders. Those signals drive each decoder's active_decN, readyout_decN and resp_decN inputs.
- Round-robin arbitration. The grant is held for bursts and locked sequences. A data-phase port register steers write data and responses.

Parameters:
- NUM_IN, 3, number of input ports (2..8).
- AW, 32, address width.
- DW, 32, data width.
- PW, clog2(NUM_IN) (min 1), port-index width, derived.

Ports:
- HCLK  in  1  AHB system clock.
- HRESET  in  1  synchronous active-high reset.
- sel_op  in  NUM_IN  per-input select from the decoders.
- addr_op  in  NUM_IN*AW  per-input HADDR, flattened, port i at [i*AW +: AW].
- trans_op  in  NUM_IN*2  per-input HTRANS.
- write_op  in  NUM_IN  per-input HWRITE.
- size_op  in  NUM_IN*3  per-input HSIZE.
- burst_op  in  NUM_IN*3  per-input HBURST.
- prot_op  in  NUM_IN*4  per-input HPROT.
- mastlock_op  in  NUM_IN  per-input HMASTLOCK.
- wdata_op  in  NUM_IN*DW  per-input HWDATA (data phase).
- HREADYM  in  1  matrix-internal HREADY for this port (transfer done).
- active_op  out  NUM_IN  one-hot: this port is servicing input i's address phase.
- readyout_op  out  1  HREADYOUT returned to all decoders.
- resp_op  out  2  HRESP returned to all decoders.
- HSELM  out  1  slave select.
- HADDRM  out  AW  slave address.
- HTRANSM  out  2  slave transfer type.
- HWRITEM  out  1  slave write.
- HSIZEM  out  3  slave size.
- HBURSTM  out  3  slave burst.
- HPROTM  out  4  slave protection.
- HMASTLOCKM  out  1  slave lock.
- HWDATAM  out  DW  slave write data.
- HREADYOUTM  in  1  slave HREADYOUT.
- HRESPM  in  2  slave HRESP.

Behaviour:
- Request: req[i] = sel_op[i] & trans_op[i][1], i.e. NONSEQ or SEQ.
- Registered state:
  - addr_port: current grant.
  - last_port: round-robin pointer.
  - data_port: port index for the data phase.
  - data_valid: a data phase is pending.
- Reset (synchronous, HRESET=1 at a rising HCLK edge) clears:
  - addr_port=0, last_port=NUM_IN-1, data_port=0, data_valid=0.
  - Outputs then read HSELM=0, HTRANSM=IDLE (00), active_op=0, readyout_op=1, resp_op=OKAY (00).
- Reset is honoured mid-burst and mid-wait-state; no transfer completes after it.
- Grant hold (no re-arbitration), when either is true:
  - the granted port shows sel & trans SEQ (11) or BUSY (01);
  - the granted port shows sel & mastlock=1.
- Arbitration point: HREADYM=1 and not holding.
  - next grant = first i with req[i], searching last_port+1 .. last_port+NUM_IN (mod NUM_IN).
  - On a grant: addr_port and last_port both take the winner at the next edge.
  - With no request: the grant parks on addr_port unchanged.
- Address phase (combinational, from the next-grant mux so the grant takes effect in the same cycle):
  - HSELM = sel_op[g].
  - HTRANSM = sel_op[g] ? trans_op[g] : IDLE.
  - Remaining controls (address, write, size, burst, prot, lock) are muxed from port g. HMASTLOCKM is additionally gated by sel.
- active_op[i] = (g==i) & sel_op[i].
  - A requesting input with active_op=0 is waiting; its decoder holds the transfer.
- Data phase: on a rising edge with HREADYM=1:
  - data_port <= g;
  - data_valid <= HSELM & HTRANSM[1].
- HWDATAM = wdata_op[data_port].
- readyout_op = data_valid ? HREADYOUTM : 1.
- resp_op = data_valid ? HRESPM : OKAY.
- ERROR handling: two-cycle ERROR responses pass through unchanged. A first-cycle ERROR with HREADYOUTM=0 does not allow arbitration, because HREADYM is low.
- Simultaneous new request and burst end: the SEQ→NONSEQ boundary of the holder is an arbitration point, so another requester may win.

Optional Feature:
- Macro: AHB_OUTSTAGE_LOCK_EN.
- Defined: lock hold as described above; HMASTLOCKM is driven.
- Undefined: mastlock_op is ignored for grant hold, and HMASTLOCKM is tied to 0.

Decomposition:
- Shared package ahb_matrix_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HRESP encodings (OKAY/ERROR);
  - HBURST encodings;
  - a function for the round-robin next-index.
- One sub-module is natural: ahb_matrix_rr_arb. It takes req, last_port and an enable, and outputs the winner index and a valid flag.

Test Plan:
- Reset: hold HRESET=1 for 2 cycles while input 0 requests NONSEQ at 0x0000_0010 → HSELM=0, HTRANSM=00, readyout_op=1. After release: HADDRM=0x10, active_op=001.
- Contention: inputs 0 and 2 raise NONSEQ in the same cycle, single transfers, HREADYOUTM=1 → granted order 0,2,0,2 on successive transfers (round-robin from last_port=2 after reset gives 0 first).
- Burst hold: input 1 runs INCR4 (NONSEQ, SEQ×3) while input 0 requests from beat 2 → input 0 is granted only on the cycle after the 4th beat's address; active_op[0]=0 throughout the burst.
- Wait states: HREADYOUTM=0 for 3 cycles on an input-2 write of 0xDEADBEEF → readyout_op=0 for 3 cycles, HWDATAM=0xDEADBEEF stable, no grant change.
- Error: slave returns ERROR for two cycles (HREADYOUTM=0 then 1) → resp_op=01 both cycles, readyout_op=0 then 1.
- Lock, with AHB_OUTSTAGE_LOCK_EN: input 0 issues locked read then write with an IDLE between, input 1 requesting → input 1 is not granted until mastlock_op[0]=0. Without the macro → input 1 is granted at the IDLE.
